// File: rtl/pzbcm_stream_demux_pkg.sv
// Shared types and select helpers for pzbcm_stream_demux and related muxing blocks.
package pzbcm_stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE   = 2'd1,
    DISCARD = 2'd2
  } pzbcm_stream_demux_state_e;

  // Selects are zero-extended to this width before legality check / decode.
  localparam int unsigned MAX_SELECT_WIDTH = 32;

  function automatic int unsigned calc_select_width(int unsigned entries, bit one_hot);
    return one_hot ? entries : int'($clog2(entries));
  endfunction

  // One-hot: exactly one bit set. Binary: value below the entry count.
  function automatic logic is_select_legal(logic [MAX_SELECT_WIDTH-1:0] sel,
                                           int unsigned entries, bit one_hot);
    int unsigned ones;
    ones = 0;
    if (one_hot) begin
      for (int unsigned i = 0; i < MAX_SELECT_WIDTH; i++) begin
        if (sel[i]) ones++;
      end
      return ones == 1;
    end
    return sel < entries;
  endfunction

  // Index of the selected entry; only meaningful when the select is legal.
  function automatic int unsigned decode_select(logic [MAX_SELECT_WIDTH-1:0] sel, bit one_hot);
    int unsigned index;
    index = 0;
    if (!one_hot) return sel;
    for (int unsigned i = 0; i < MAX_SELECT_WIDTH; i++) begin
      if (sel[i]) index = i;
    end
    return index;
  endfunction

endpackage

// File: rtl/pzbcm_stream_demux_decoder.sv
// Combinational select decoder: select -> {legal, index}.
module pzbcm_stream_demux_decoder
  import pzbcm_stream_demux_pkg::*;
#(
  parameter int unsigned ENTRIES      = 2,
  parameter bit          ONE_HOT      = 1'b1,
  parameter int unsigned SELECT_WIDTH = calc_select_width(ENTRIES, ONE_HOT),
  parameter int unsigned INDEX_WIDTH  = $clog2(ENTRIES)
)(
  input  logic [SELECT_WIDTH-1:0] i_select,
  output logic                    o_legal,
  output logic [INDEX_WIDTH-1:0]  o_index
);

  logic [MAX_SELECT_WIDTH-1:0] w_select;

  // Widen the select and evaluate the shared package helpers.
  always_comb begin
    w_select = MAX_SELECT_WIDTH'(i_select);
    o_legal  = is_select_legal(w_select, ENTRIES, ONE_HOT);
    o_index  = INDEX_WIDTH'(decode_select(w_select, ONE_HOT));
  end

endmodule

// File: rtl/pzbcm_stream_demux.sv
// Packet-level valid/ready stream demultiplexer with one registered stage.
// Optional drop counter: define PZBCM_STREAM_DEMUX_DROP_COUNTER_EN.
module pzbcm_stream_demux
  import pzbcm_stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter type         TYPE    = logic [WIDTH-1:0],
  parameter int unsigned ENTRIES = 2,
  parameter bit          ONE_HOT = 1'b1,
  localparam int unsigned SELECT_WIDTH = calc_select_width(ENTRIES, ONE_HOT)
)(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [SELECT_WIDTH-1:0] i_select,
  input  logic                    i_last,
  input  TYPE                     i_data,
  output logic [ENTRIES-1:0]      o_valid,
  input  logic [ENTRIES-1:0]      i_ready,
  output logic [ENTRIES-1:0]      o_last,
  output TYPE                     o_data [ENTRIES],
  output logic                    o_drop
`ifdef PZBCM_STREAM_DEMUX_DROP_COUNTER_EN
  ,
  input  logic                    i_drop_count_clear,
  output logic [15:0]             o_drop_count
`endif
);

  localparam int unsigned INDEX_WIDTH = $clog2(ENTRIES);

  pzbcm_stream_demux_state_e r_state;
  logic [INDEX_WIDTH-1:0]    r_route_dest;
  logic                      r_drop;
  logic                      r_valid;
  logic                      r_last;
  logic [INDEX_WIDTH-1:0]    r_dest;
  TYPE                       r_data;

  logic                      w_legal;
  logic [INDEX_WIDTH-1:0]    w_index;
  logic                      w_fire;
  logic                      w_accept;
  logic                      w_load;
  logic                      w_drop_end;
  logic [INDEX_WIDTH-1:0]    w_load_dest;

  pzbcm_stream_demux_decoder #(
    .ENTRIES      (ENTRIES),
    .ONE_HOT      (ONE_HOT),
    .SELECT_WIDTH (SELECT_WIDTH),
    .INDEX_WIDTH  (INDEX_WIDTH)
  ) u_decoder (
    .i_select (i_select),
    .o_legal  (w_legal),
    .o_index  (w_index)
  );

  // Handshake, stage-load and drop-end decisions for the current cycle.
  always_comb begin
    w_fire      = r_valid && i_ready[r_dest];
    o_ready     = (r_state == DISCARD) || !r_valid || i_ready[r_dest];
    w_accept    = i_valid && o_ready;
    w_load      = 1'b0;
    w_load_dest = r_route_dest;
    w_drop_end  = 1'b0;
    case (r_state)
      IDLE: begin
        w_load      = w_accept && w_legal;
        w_load_dest = w_index;
        w_drop_end  = w_accept && !w_legal && i_last;
      end
      ROUTE:   w_load     = w_accept;
      DISCARD: w_drop_end = w_accept && i_last;
      default: ;
    endcase
  end

  // Packet FSM: locks the destination for the body of a packet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_route_dest <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= w_drop_end;
      case (r_state)
        IDLE: begin
          if (w_accept && !i_last) begin
            if (w_legal) begin
              r_state      <= ROUTE;
              r_route_dest <= w_index;
            end else begin
              r_state <= DISCARD;
            end
          end
        end
        ROUTE, DISCARD: begin
          if (w_accept && i_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output stage: a load takes priority so fire+accept reloads without a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_dest  <= '0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_dest  <= w_load_dest;
      r_last  <= i_last;
      r_data  <= i_data;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end

  // Fan the stage out to every destination; only valid/last are steered.
  always_comb begin
    for (int unsigned k = 0; k < ENTRIES; k++) begin
      o_valid[k] = r_valid && (r_dest == INDEX_WIDTH'(k));
      o_last[k]  = r_valid && r_last && (r_dest == INDEX_WIDTH'(k));
      o_data[k]  = r_data;
    end
  end

  assign o_drop = r_drop;

`ifdef PZBCM_STREAM_DEMUX_DROP_COUNTER_EN
  logic [15:0] r_drop_count;

  // Saturating dropped-packet counter; clear beats a coincident increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_drop_count_clear) begin
      r_drop_count <= '0;
    end else if (r_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign o_drop_count = r_drop_count;
`endif

endmodule
